// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, instruction fields.
package alu_pkg;

  localparam int OP_W     = 4;
  localparam int ALU_OP_W = 5;

  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA = 4'd7;
  localparam logic [OP_W-1:0] OP_SLL = 4'd8;
  localparam logic [OP_W-1:0] OP_LDI = 4'd15;

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SLL);
  endfunction

  function automatic logic [15:0] sext_imm8(input logic [7:0] imm);
    return {{8{imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// NREGS x DATA_W register file: two async read ports, one sync write port, sync clear.
// ALU_CTRL_R0_ZERO_EN: r0 reads as zero and writes to it are dropped.
module alu_ctrl_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int IDX_W  = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [IDX_W-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

`ifdef ALU_CTRL_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_wr_ok;

  assign w_wr_ok = we_i && !(R0_ZERO && (waddr_i == '0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (R0_ZERO && (raddr_a_i == '0)) ? '0 : r_mem[raddr_a_i];
  assign rdata_b_o = (R0_ZERO && (raddr_b_i == '0)) ? '0 : r_mem[raddr_b_i];

endmodule

// File: rtl/alu_ctrl.sv
// Four-state sequencer (IDLE/READ/EXEC/WB) feeding a combinational ALU and writing back.
// Optional macro ALU_CTRL_R0_ZERO_EN hard-wires r0 to zero (handled in the register file).
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [15:0]       instr_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [4:0]        alu_opcode_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic [DATA_W-1:0] result_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(NREGS);

  state_t              r_state;
  logic [15:0]         r_ir;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [4:0]          r_alu_op;
  logic [DATA_W-1:0]   r_result;
  logic                r_done;
  logic                r_err;
  logic                r_wr;

  logic [OP_W-1:0]     w_op;
  logic [IDX_W-1:0]    w_rd;
  logic [IDX_W-1:0]    w_rs;
  logic [IDX_W-1:0]    w_rt;
  logic [7:0]          w_imm;
  logic [DATA_W-1:0]   w_rf_a;
  logic [DATA_W-1:0]   w_rf_b;
  logic                w_we;

  assign w_op  = r_ir[OP_MSB:OP_LSB];
  assign w_rd  = r_ir[RD_MSB:RD_LSB];
  assign w_rs  = r_ir[RS_MSB:RS_LSB];
  assign w_rt  = r_ir[RT_MSB:RT_LSB];
  assign w_imm = r_ir[IMM_MSB:IMM_LSB];

  // Write happens on the WB->IDLE edge; reset on that edge clears instead.
  assign w_we = (r_state == ST_WB) && r_wr;

  alu_ctrl_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (w_we),
    .waddr_i   (w_rd),
    .wdata_i   (r_result),
    .raddr_a_i (w_rs),
    .rdata_a_o (w_rf_a),
    .raddr_b_i (w_rt),
    .rdata_b_o (w_rf_b)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_ir     <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_wr     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_wr   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid_i) begin
            r_ir    <= instr_i;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          // Operand registers double as the EXEC-cycle ALU drive.
          r_alu_a  <= w_rf_a;
          r_alu_b  <= w_rf_b;
          r_alu_op <= is_alu_op(w_op) ? {1'b0, w_op} : '0;
          r_state  <= ST_EXEC;
        end
        ST_EXEC: begin
          r_alu_a  <= '0;
          r_alu_b  <= '0;
          r_alu_op <= '0;
          r_state  <= ST_WB;
          if (is_alu_op(w_op)) begin
            r_result <= alu_result_i;
            r_done   <= 1'b1;
            r_wr     <= 1'b1;
          end else if (w_op == OP_LDI) begin
            r_result <= sext_imm8(w_imm);
            r_done   <= 1'b1;
            r_wr     <= 1'b1;
          end else if (w_op == OP_NOP) begin
            r_result <= '0;
            r_done   <= 1'b1;
          end else begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        ST_WB: begin
          r_result <= '0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready_o = (r_state == ST_IDLE);
  assign alu_a_o       = r_alu_a;
  assign alu_b_o       = r_alu_b;
  assign alu_opcode_o  = r_alu_op;
  assign result_o      = r_result;
  assign done_o        = r_done;
  assign err_o         = r_err;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: table-driven instruction stream through a bench-side ALU, scoreboarded retirements.
module tb_alu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [15:0] alu_a_o, alu_b_o, alu_result_i, result_o;
  logic [4:0]  alu_opcode_o;
  logic        done_o, err_o;

  int total = 0;
  int bad   = 0;

  typedef struct {logic [15:0] instr; logic [15:0] res; logic err;} vec_t;
  typedef struct {logic [15:0] res; logic err;} exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[$];

  alu_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .alu_a_o       (alu_a_o),
    .alu_b_o       (alu_b_o),
    .alu_opcode_o  (alu_opcode_o),
    .alu_result_i  (alu_result_i),
    .result_o      (result_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Combinational ALU the controller drives.
  always_comb begin
    alu_result_i = '0;
    case (alu_opcode_o)
      5'd1: alu_result_i = alu_a_o + alu_b_o;
      5'd2: alu_result_i = alu_a_o - alu_b_o;
      5'd3: alu_result_i = alu_a_o & alu_b_o;
      5'd4: alu_result_i = alu_a_o | alu_b_o;
      5'd5: alu_result_i = alu_a_o ^ alu_b_o;
      5'd6: alu_result_i = alu_a_o >> alu_b_o[3:0];
      5'd7: alu_result_i = 16'($signed(alu_a_o) >>> alu_b_o[3:0]);
      5'd8: alu_result_i = alu_a_o << alu_b_o[3:0];
      default: alu_result_i = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (done_o || err_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected retire", {30'd0, done_o, err_o}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("retire err", {31'd0, err_o}, {31'd0, mon_e.err});
        chk("retire done", {31'd0, done_o}, {31'd0, !mon_e.err});
        if (!mon_e.err) chk("result", {16'd0, result_o}, {16'd0, mon_e.res});
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first IDLE cycle after WB.
  task automatic issue(input logic [15:0] ins, input logic [15:0] res, input logic err,
                       input logic hold, input logic nowait);
    int w = 0;
    logic [3:0] op;
    logic [4:0] exp_op;
    op = ins[15:12];
    exp_op = (op >= 4'd1 && op <= 4'd8) ? {1'b0, op} : 5'd0;
    while (!instr_ready_o && w < 8) begin
      @(negedge clk_i);
      w++;
    end
    if (!instr_ready_o) begin
      chk("ready timeout", {31'd0, instr_ready_o}, 32'd1);
      return;
    end
    if (nowait) chk("accept first idle", w, 0);
    instr_i = ins;
    instr_valid_i = 1'b1;
    sb_q.push_back('{res: res, err: err});
    @(posedge clk_i);
    #1;
    if (!hold) instr_valid_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      chk("ready busy", {31'd0, instr_ready_o}, 32'd0);
      if (k == 2) begin
        chk("exec opcode", {27'd0, alu_opcode_o}, {27'd0, exp_op});
      end else begin
        chk("alu idle zero", {alu_a_o, alu_b_o | {11'd0, alu_opcode_o}}, 32'd0);
      end
      chk("retire timing", {31'd0, done_o | err_o}, {31'd0, k == 3});
    end
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      '{16'hF105, 16'h0005, 1'b0},  // LDI r1,#5
      '{16'hF2FD, 16'hFFFD, 1'b0},  // LDI r2,#-3
      '{16'h1312, 16'h0002, 1'b0},  // ADD r3,r1,r2
      '{16'hF480, 16'hFF80, 1'b0},  // LDI r4,#0x80
      '{16'hF604, 16'h0004, 1'b0},  // LDI r6,#4
      '{16'h7546, 16'hFFF8, 1'b0},  // SRA r5,r4,r6
      '{16'h6546, 16'h0FF8, 1'b0},  // SRL r5,r4,r6
      '{16'h2712, 16'h0008, 1'b0},  // SUB r7,r1,r2
      '{16'h8816, 16'h0050, 1'b0},  // SLL r8,r1,r6
      '{16'h3942, 16'hFF80, 1'b0},  // AND r9,r4,r2
      '{16'h4A16, 16'h0005, 1'b0},  // OR  r10,r1,r6
      '{16'h5B16, 16'h0001, 1'b0},  // XOR r11,r1,r6
      '{16'hA312, 16'h0000, 1'b1},  // illegal, rd=r3
      '{16'h4B33, 16'h0002, 1'b0},  // r3 unchanged
      '{16'h0345, 16'h0000, 1'b0},  // NOP with rd=r3
      '{16'h4C33, 16'h0002, 1'b0},  // r3 still unchanged
      '{16'h1331, 16'h0007, 1'b0},  // ADD r3,r3,r1
      '{16'h9312, 16'h0000, 1'b1},  // illegal 9
      '{16'hE312, 16'h0000, 1'b1},  // illegal 14
      '{16'h4C33, 16'h0007, 1'b0},  // r3 = 7
      '{16'h1D44, 16'hFF00, 1'b0},  // ADD wraps
      '{16'h2D21, 16'hFFF8, 1'b0}   // SUB r13,r2,r1
    };

    rst_i = 1'b1;
    instr_valid_i = 1'b0;
    instr_i = '0;
    repeat (2) @(negedge clk_i);
    chk("reset ready", {31'd0, instr_ready_o}, 32'd1);
    chk("reset done/err", {30'd0, done_o, err_o}, 32'd0);
    chk("reset alu a/b", {alu_a_o, alu_b_o}, 32'd0);
    chk("reset opcode/result", {11'd0, alu_opcode_o, result_o}, 32'd0);
    rst_i = 1'b0;

    // valid held high across the whole table
    foreach (vecs[i]) issue(vecs[i].instr, vecs[i].res, vecs[i].err, 1'b1, 1'b1);
    instr_valid_i = 1'b0;
    @(negedge clk_i);

    // reset during EXEC of ADD r3,r1,r2
    instr_i = 16'h1312;
    instr_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    instr_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("abort exec opcode", {27'd0, alu_opcode_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("abort ready", {31'd0, instr_ready_o}, 32'd1);
    chk("abort done/err", {30'd0, done_o, err_o}, 32'd0);
    chk("abort alu zero", {alu_a_o, alu_b_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post-abort no retire", {30'd0, done_o, err_o}, 32'd0);
    issue(16'h4B33, 16'h0000, 1'b0, 1'b0, 1'b1);  // r3 cleared
    issue(16'h4911, 16'h0000, 1'b0, 1'b0, 1'b1);  // r1 cleared

    // r0 behaviour
    issue(16'hF007, 16'h0007, 1'b0, 1'b0, 1'b1);
`ifdef ALU_CTRL_R0_ZERO_EN
    issue(16'h1100, 16'h0000, 1'b0, 1'b0, 1'b1);
`else
    issue(16'h1100, 16'h000E, 1'b0, 1'b0, 1'b1);
`endif

    repeat (3) @(negedge clk_i);
    chk("scoreboard drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
